merlin_ibus_dbus_arbiter: RTL

//   Shares one memory target port between the merlin32i instruction and data ports.

---
 rtl/merlin_ibus_dbus_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/merlin_ibus_dbus_arbiter.sv
// ============================================================================
// Module      : merlin_ibus_dbus_arbiter
// Description : Round-robin share of one memory target between the merlin32i
//               instruction and data ports, with in-order response routing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module merlin_ibus_dbus_arbiter #(
  parameter int C_DEPTH   = 4,
  parameter int C_ADDR_SZ = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  // instruction port
  output logic                 ireqready_o,
  input  logic                 ireqvalid_i,
  input  logic [1:0]           ireqhpl_i,
  input  logic [C_ADDR_SZ-1:0] ireqaddr_i,
  input  logic                 irspready_i,
  output logic                 irspvalid_o,
  output logic                 irsprerr_o,
  output logic [31:0]          irspdata_o,
  // data port
  output logic                 dreqready_o,
  input  logic                 dreqvalid_i,
  input  logic [1:0]           dreqhpl_i,
  input  logic [C_ADDR_SZ-1:0] dreqaddr_i,
  input  logic                 drspready_i,
  output logic                 drspvalid_o,
  output logic                 drsprerr_o,
  output logic                 drspwerr_o,
  output logic [31:0]          drspdata_o,
  // target port
  input  logic                 treqready_i,
  output logic                 treqvalid_o,
  output logic [1:0]           treqhpl_o,
  output logic [C_ADDR_SZ-1:0] treqaddr_o,
  output logic                 trspready_o,
  input  logic                 trspvalid_i,
  input  logic                 trsprerr_i,
  input  logic                 trspwerr_i,
  input  logic [31:0]          trspdata_i
);

  localparam int                 C_PTR_W = $clog2(C_DEPTH);
  localparam int                 C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_FULL  = C_CNT_W'(C_DEPTH);
  localparam logic               C_ID_I  = 1'b0;
  localparam logic               C_ID_D  = 1'b1;

  logic [C_CNT_W-1:0] count_q, count_d;
  logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic               last_grant_q, last_grant_d;
  logic               id_mem_q [C_DEPTH];

  logic w_any_valid;
  logic w_grant;
  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_push;
  logic w_pop;

  assign w_full      = (count_q == C_FULL);
  assign w_empty     = (count_q == '0);
  assign w_any_valid = ireqvalid_i | dreqvalid_i;
  assign w_head      = id_mem_q[rd_ptr_q];

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    w_grant = C_ID_I;
    if (ireqvalid_i && dreqvalid_i) begin
      w_grant = ~last_grant_q;
    end else if (dreqvalid_i) begin
      w_grant = C_ID_D;
    end
  end

  // Request path: combinational pass-through, masked while in reset.
  always_comb begin
    treqvalid_o = ~reset_i & w_any_valid & ~w_full;
    ireqready_o = ~reset_i & treqready_i & ~w_full & ireqvalid_i & (w_grant == C_ID_I);
    dreqready_o = ~reset_i & treqready_i & ~w_full & dreqvalid_i & (w_grant == C_ID_D);
    treqhpl_o   = '0;
    treqaddr_o  = '0;
    if (w_any_valid) begin
      treqhpl_o  = (w_grant == C_ID_D) ? dreqhpl_i  : ireqhpl_i;
      treqaddr_o = (w_grant == C_ID_D) ? dreqaddr_i : ireqaddr_i;
    end
  end

  // Response path: the oldest outstanding ID picks the destination.
  always_comb begin
    irspvalid_o = ~reset_i & trspvalid_i & ~w_empty & (w_head == C_ID_I);
    drspvalid_o = ~reset_i & trspvalid_i & ~w_empty & (w_head == C_ID_D);
    trspready_o = ~reset_i & ~w_empty & ((w_head == C_ID_D) ? drspready_i : irspready_i);
    irsprerr_o  = trsprerr_i;
    irspdata_o  = trspdata_i;
    drsprerr_o  = trsprerr_i;
    drspwerr_o  = trspwerr_i;
    drspdata_o  = trspdata_i;
  end

  assign w_push = treqvalid_o & treqready_i;
  assign w_pop  = trspvalid_i & trspready_o;

  always_comb begin
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    last_grant_d = last_grant_q;
    if (w_push) begin
      wr_ptr_d     = wr_ptr_q + C_PTR_W'(1);
      last_grant_d = w_grant;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + C_CNT_W'(1);
      2'b01:   count_d = count_q - C_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      last_grant_q <= C_ID_D;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      last_grant_q <= last_grant_d;
    end
  end

  // ID storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      id_mem_q[wr_ptr_q] <= w_grant;
    end
  end

endmodule

`default_nettype wire
